key_matrix_scan: RTL and testbench
==================================

Name: key_matrix_scan

Overview:
- CPU-bus input peripheral: scans a 4x4 active-low key matrix, debounces it, and records key-press events in a 4-entry FIFO.
- The CPU reads status and key codes through the same wr/waddr/wdata/rd/raddr/rdata register interface used by the display peripheral.
- This block is the input-side counterpart of the scanned 7-segment output: column-strobe outputs drive the matrix and row inputs are sampled.

Parameters:
- ADDRWIDTH, 4, register address width.
- SCAN_DIV, 25000, clk cycles per column dwell. Legal range 2..65535.
- DEBOUNCE, 3, consecutive identical full-matrix frames required before the stable state updates. Legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- wr  in  1  write strobe.
- waddr  in  ADDRWIDTH  write address.
- wdata  in  32  write data.
- rd  in  1  read strobe.
- raddr  in  ADDRWIDTH  read address.
- rdata  out  32  registered read data.
- col_out  out  4  column strobes, active-low one-hot.
- row_in  in  4  row sense lines, active-low, asynchronous to clk.

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-low; all flops clear on reset. No derived clocks; scan timing uses a clock-enable tick.
- Register map:
  - 'h00 STATUS (read-only): bit0 fifo_not_empty; bit1 overflow (sticky); bit2 any_key_down (debounced); bits[5:3] fifo count 0..4.
  - 'h04 KEY_DATA (read pops): bit8 valid; bits[3:0] key code. Reading when empty returns 0 and does not pop.
  - 'h08 CTRL (R/W): bit0 scan_en, reset value 1. Writing bit1=1 clears overflow; bit1 is self-clearing and reads 0.
  - Any other address: writes are ignored; reads return 0.
- Read timing: rdata is registered. It updates on the clk edge after the rd cycle and is 0 on every cycle without a valid read, matching the display block. A KEY_DATA pop takes effect on that same edge.
- Scan timing:
  - A 16-bit divider counts 0..SCAN_DIV-1. The tick fires at count SCAN_DIV-1.
  - col_out resets to 4'b1110 (column 0). Each tick rotates to the next column, 0→1→2→3→0.
  - row_in passes through a 2-flop synchronizer. Its value is sampled into frame[col*4+row] on the tick cycle, before the column advances, so each column has a full dwell to settle.
  - A frame completes on the tick that leaves column 3.
- Scan disable: when scan_en=0, the divider holds at 0, col_out=4'b1111, debounce state is preserved, and no events are generated. Re-enabling restarts at column 0 with a fresh frame.
- Debounce:
  - On frame complete, if frame equals prev_frame, stab_cnt increments (saturating). Otherwise stab_cnt goes to 1 and prev_frame takes frame.
  - When stab_cnt reaches DEBOUNCE, stable is loaded from frame.
  - press_mask = new stable & ~old stable. Key code = col*4+row.
  - If press_mask is nonzero, the lowest-index newly pressed key is pushed. Other simultaneous new presses are discarded and do not set overflow.
  - Releases generate no events. any_key_down = |stable.
- FIFO: 4 entries × 4 bits, with pointer wrap.
  - Push when full: data is dropped and overflow is set.
  - Push and pop on the same cycle when full: both succeed, count stays 4, overflow is not set.
  - Push and pop on the same cycle when empty: the pop is a no-op and returns 0, the push succeeds, count becomes 1.
- Reset mid-scan or mid-debounce: everything returns to reset values (col 0, empty FIFO, stable=0, overflow=0, rdata=0). No spurious event is produced afterwards for a key already held down until it has debounced.

Decomposition:
- Shared peripheral package holds:
  - ADDR_KEY_STATUS = 'h00, ADDR_KEY_DATA = 'h04, ADDR_KEY_CTRL = 'h08.
  - STATUS bit-index constants.
  - KEY_CODE_W = 4.
- One sub-module, key_event_fifo: parameterised depth 4 and width 4, push/pop/full/empty/count, synchronous within clk, async active-low reset.
- Divider, synchronizer, debounce and register decode stay in the top module.

Test Plan (SCAN_DIV=4, DEBOUNCE=2 unless noted):
- Reset: after reset, col_out=4'b1110, STATUS read returns 0, CTRL read returns 1, rdata=0 on idle cycles.
- Single press: hold row_in=4'b1011 while col_out=4'b1101 (key col1 row2) for 4 frames. STATUS reads 'h0D (not_empty, down, count 1). KEY_DATA reads 'h106, then STATUS count is 0.
- Bounce: toggle key 5 every frame for 6 frames, then release. No event is pushed and any_key_down stays 0.
- Overflow: press and release keys 0,1,2,3,4 in turn without reading. Count is 4 and overflow=1. Four reads return codes 0,1,2,3. Writing CTRL 'h3 clears overflow and keeps scan enabled.
- Simultaneous press: keys 9 and 14 debounce in the same frame. Exactly one event is pushed, code 9.
- Empty read and disable:
  - KEY_DATA read with FIFO empty returns 0 and count stays 0.
  - Writing CTRL 'h0 forces col_out=4'b1111 and a held key produces no event.
  - Writing CTRL 'h1 restarts at col_out=4'b1110.

Source files
------------

// File: rtl/key_matrix_scan_pkg.sv
// Shared constants for the key matrix scanner: register addresses, STATUS
// bit positions and the key-code width, plus a priority helper.
package key_matrix_scan_pkg;

  localparam int ADDR_KEY_STATUS = 'h00;
  localparam int ADDR_KEY_DATA   = 'h04;
  localparam int ADDR_KEY_CTRL   = 'h08;

  localparam int STAT_NOT_EMPTY = 0;
  localparam int STAT_OVERFLOW  = 1;
  localparam int STAT_KEY_DOWN  = 2;
  localparam int STAT_COUNT_LSB = 3;

  localparam int KEY_DATA_VALID = 8;
  localparam int KEY_CODE_W     = 4;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [KEY_CODE_W-1:0] lowest_index(input logic [15:0] mask);
    logic [KEY_CODE_W-1:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (mask[i]) idx = KEY_CODE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Small synchronous FIFO for key codes. A pop on empty is a no-op; a push
// on full is accepted only when a pop frees a slot in the same cycle.
module key_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/key_matrix_scan.sv
// 4x4 active-low key matrix scanner with frame debounce, a press-event FIFO
// and a registered CPU read/write port.
module key_matrix_scan
  import key_matrix_scan_pkg::*;
#(
  parameter int ADDRWIDTH = 4,
  parameter int SCAN_DIV  = 25000,
  parameter int DEBOUNCE  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr,
  input  logic [ADDRWIDTH-1:0] waddr,
  input  logic [31:0]          wdata,
  input  logic                 rd,
  input  logic [ADDRWIDTH-1:0] raddr,
  output logic [31:0]          rdata,
  output logic [3:0]           col_out,
  input  logic [3:0]           row_in
);

  logic        scan_en;
  logic        overflow;
  logic [15:0] div_cnt;
  logic [1:0]  col_idx;
  logic [3:0]  row_meta;
  logic [3:0]  row_sync;
  logic [15:0] frame;
  logic [15:0] frame_next;
  logic [15:0] prev_frame;
  logic [15:0] stable;
  logic [15:0] press_mask;
  logic [3:0]  stab_cnt;
  logic [3:0]  stab_next;
  logic        tick;
  logic        frame_done;
  logic        load_stable;
  logic        push;
  logic [KEY_CODE_W-1:0] push_code;
  logic        pop;
  logic [KEY_CODE_W-1:0] pop_data;
  logic        fifo_full;
  logic        fifo_empty;
  logic [2:0]  fifo_count;
  logic        wr_ctrl;
  logic        unused_bits;

  assign unused_bits = ^wdata[31:2];

  assign tick       = scan_en && (div_cnt == 16'(SCAN_DIV - 1));
  assign frame_done = tick && (col_idx == 2'd3);
  assign col_out    = scan_en ? ~(4'b0001 << col_idx) : 4'b1111;
  assign wr_ctrl    = wr && (waddr == ADDRWIDTH'(ADDR_KEY_CTRL));
  assign pop        = rd && (raddr == ADDRWIDTH'(ADDR_KEY_DATA)) && !fifo_empty;

  // The column being left is folded in so a completed frame is whole.
  always_comb begin
    frame_next = frame;
    for (int r = 0; r < 4; r++) begin
      frame_next[{col_idx, 2'(r)}] = ~row_sync[r];
    end
  end

  always_comb begin
    if (frame_next == prev_frame) begin
      stab_next = (stab_cnt == 4'hF) ? stab_cnt : stab_cnt + 4'd1;
    end else begin
      stab_next = 4'd1;
    end
  end

  assign load_stable = frame_done && (stab_next >= 4'(DEBOUNCE));
  assign press_mask  = frame_next & ~stable;
  assign push        = load_stable && (|press_mask);
  assign push_code   = lowest_index(press_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row_in;
      row_sync <= row_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      col_idx <= '0;
      frame   <= '0;
    end else if (!scan_en) begin
      div_cnt <= '0;
      col_idx <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      col_idx <= col_idx + 2'd1;
      frame   <= frame_next;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_frame <= '0;
      stab_cnt   <= '0;
      stable     <= '0;
    end else if (frame_done) begin
      prev_frame <= frame_next;
      stab_cnt   <= stab_next;
      if (load_stable) stable <= frame_next;
    end
  end

  // A fresh overflow in the same cycle as a clear request wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_en  <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (wr_ctrl) scan_en <= wdata[0];
      if (push && fifo_full && !pop) overflow <= 1'b1;
      else if (wr_ctrl && wdata[1]) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else begin
      rdata <= '0;
      if (rd) begin
        case (raddr)
          ADDRWIDTH'(ADDR_KEY_STATUS): begin
            rdata[STAT_NOT_EMPTY]                 <= !fifo_empty;
            rdata[STAT_OVERFLOW]                  <= overflow;
            rdata[STAT_KEY_DOWN]                  <= |stable;
            rdata[STAT_COUNT_LSB+2:STAT_COUNT_LSB] <= fifo_count;
          end
          ADDRWIDTH'(ADDR_KEY_DATA): begin
            if (!fifo_empty) begin
              rdata[KEY_DATA_VALID]   <= 1'b1;
              rdata[KEY_CODE_W-1:0]   <= pop_data;
            end
          end
          ADDRWIDTH'(ADDR_KEY_CTRL): rdata[0] <= scan_en;
          default: rdata <= '0;
        endcase
      end
    end
  end

  key_event_fifo #(
    .DEPTH (4),
    .WIDTH (KEY_CODE_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_code),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_key_matrix_scan.sv
// Directed bench for key_matrix_scan: a behavioural 4x4 matrix drives row_in
// from col_out and a held-key mask; expected register values are hand-derived.
module tb_key_matrix_scan;

  localparam int AW    = 4;
  localparam int FRAME = 16;

  logic          clk;
  logic          rst_n;
  logic          wr;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic          rd;
  logic [AW-1:0] raddr;
  logic [31:0]   rdata;
  logic [3:0]    col_out;
  logic [3:0]    row_in;
  logic [15:0]   keys;
  logic [31:0]   rv;

  int checks;
  int errors;

  key_matrix_scan #(
    .ADDRWIDTH (AW),
    .SCAN_DIV  (4),
    .DEBOUNCE  (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr      (wr),
    .waddr   (waddr),
    .wdata   (wdata),
    .rd      (rd),
    .raddr   (raddr),
    .rdata   (rdata),
    .col_out (col_out),
    .row_in  (row_in)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // matrix model: a held key pulls its row low while its column is strobed
  always_comb begin
    row_in = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (keys[c*4+r] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_read(input logic [AW-1:0] a, output logic [31:0] d);
    @(negedge clk);
    rd    = 1'b1;
    raddr = a;
    @(negedge clk);
    rd    = 1'b0;
    raddr = '0;
    d     = rdata;
  endtask

  task automatic bus_write(input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk);
    wr    = 1'b1;
    waddr = a;
    wdata = d;
    @(negedge clk);
    wr    = 1'b0;
    waddr = '0;
    wdata = '0;
  endtask

  task automatic press_release(input int k, input int hold);
    keys = 16'(1) << k;
    cycles(hold);
    keys = '0;
    cycles(hold);
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    checks = 0;
    errors = 0;
    keys   = '0;
    wr     = 1'b0;
    waddr  = '0;
    wdata  = '0;
    rd     = 1'b0;
    raddr  = '0;
    rst_n  = 1'b0;
    cycles(3);
    rst_n = 1'b1;

    // reset state
    check("reset_col", 32'(col_out), 32'h0000_000E);
    check("reset_rdata", rdata, 32'h0);
    bus_read(4'h0, rv); check("reset_status", rv, 32'h0);
    bus_read(4'h8, rv); check("reset_ctrl", rv, 32'h1);
    cycles(1);          check("idle_rdata", rdata, 32'h0);
    bus_read(4'hC, rv); check("unmapped_read", rv, 32'h0);

    // single press: key col1 row2 = code 6
    keys = 16'h0040;
    cycles(4 * FRAME);
    bus_read(4'h0, rv); check("press_status", rv, 32'h0000_000D);
    bus_read(4'h4, rv); check("press_data", rv, 32'h0000_0106);
    bus_read(4'h0, rv); check("press_status_after_pop", rv, 32'h0000_0004);
    keys = '0;
    cycles(4 * FRAME);
    bus_read(4'h0, rv); check("release_status", rv, 32'h0);

    // bounce: key 5 changes every frame, never stable for two frames
    for (int i = 0; i < 6; i++) begin
      keys[5] = ~keys[5];
      cycles(FRAME - 2);
      bus_read(4'h0, rv); check("bounce_status", rv, 32'h0);
    end
    keys = '0;
    cycles(4 * FRAME);
    bus_read(4'h0, rv); check("bounce_final", rv, 32'h0);

    // overflow: five presses into a four-deep FIFO
    for (int k = 0; k < 5; k++) press_release(k, 4 * FRAME);
    bus_read(4'h0, rv); check("ovf_status", rv, 32'h0000_0023);
    for (int k = 0; k < 4; k++) begin
      bus_read(4'h4, rv); check("ovf_data", rv, 32'h100 + 32'(k));
    end
    bus_read(4'h4, rv); check("ovf_drained_read", rv, 32'h0);
    bus_read(4'h0, rv); check("ovf_sticky", rv, 32'h0000_0002);
    bus_write(4'h8, 32'h3);
    bus_read(4'h0, rv); check("ovf_cleared", rv, 32'h0);
    bus_read(4'h8, rv); check("ovf_ctrl", rv, 32'h1);

    // simultaneous presses of 9 and 14: only the lowest is queued
    keys = 16'h4200;
    cycles(4 * FRAME);
    bus_read(4'h0, rv); check("simul_status", rv, 32'h0000_000D);
    bus_read(4'h4, rv); check("simul_data", rv, 32'h0000_0109);
    bus_read(4'h0, rv); check("simul_status_after", rv, 32'h0000_0004);
    keys = '0;
    cycles(4 * FRAME);

    // empty read
    bus_read(4'h4, rv); check("empty_data", rv, 32'h0);
    bus_read(4'h0, rv); check("empty_status", rv, 32'h0);

    // disable: no strobes and no events while a key is held
    bus_write(4'h8, 32'h0);
    cycles(1);
    check("disabled_col", 32'(col_out), 32'h0000_000F);
    keys = 16'h0008;
    cycles(6 * FRAME);
    check("disabled_col_held", 32'(col_out), 32'h0000_000F);
    bus_read(4'h0, rv); check("disabled_status", rv, 32'h0);
    bus_read(4'h8, rv); check("disabled_ctrl", rv, 32'h0);
    keys = '0;
    bus_write(4'h8, 32'h1);
    check("reenable_col0", 32'(col_out), 32'h0000_000E);
    cycles(3);
    check("reenable_dwell", 32'(col_out), 32'h0000_000E);
    cycles(1);
    check("reenable_col1", 32'(col_out), 32'h0000_000D);

    // reset in the middle of debouncing a held key
    keys = 16'h0040;
    cycles(FRAME + 4);
    @(negedge clk);
    rst_n = 1'b0;
    cycles(1);
    check("midreset_col", 32'(col_out), 32'h0000_000E);
    check("midreset_rdata", rdata, 32'h0);
    cycles(2);
    rst_n = 1'b1;
    cycles(18);
    bus_read(4'h0, rv); check("midreset_no_early_event", rv, 32'h0);
    cycles(30);
    bus_read(4'h0, rv); check("midreset_debounced", rv, 32'h0000_000D);
    bus_read(4'h4, rv); check("midreset_data", rv, 32'h0000_0106);
    keys = '0;
    cycles(4 * FRAME);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
